// File: rtl/fetch_pkg.sv
// Shared constants and the FIFO entry type for the instruction fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  fetch_entry_t      push_data,
  output fetch_entry_t      head,
  output logic [CNT_W-1:0]  count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, in-flight tracking, credit-based issue into a prefetch FIFO.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_PERF_EN
 ,output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] issue_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight_v;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              pop;
  logic              issue;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign imem_addr = issue_pc >> 2;
  assign pop       = out_valid && out_ready;

  // Entries that will occupy the FIFO next cycle if we do not issue; a new
  // fetch is only allowed while that leaves room for its returning data.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_v}
                   - {{CNT_W{1'b0}}, pop};
  assign issue     = !redirect_valid && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_pc    <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      issue_pc    <= redirect_pc & ~ADDR_W'(3);
      inflight_v  <= 1'b0;
    end else if (issue) begin
      inflight_v  <= 1'b1;
      inflight_pc <= issue_pc;
      issue_pc    <= issue_pc + ADDR_W'(PC_STEP);
    end else begin
      inflight_v  <= 1'b0;
    end
  end

  assign push_entry = '{pc: inflight_pc, instr: imem_data};

  // Redirect flushes the FIFO, which also discards returning data and voids any pop.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_v),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .head      (head),
    .count     (count)
  );

  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (issue)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {pc, instr}, a negedge monitor checks every handshake.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_popped = 0;
  int   p0;

  fetch_unit #(
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
   ,.perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(logic [31:0] w);
    case (w)
      32'd0:   return 32'h0000_0000;
      32'd1:   return 32'h2003_0001;
      32'd2:   return 32'h2203_0001;
      default: return {w[15:0], ~w[15:0]};
    endcase
  endfunction

  // Synchronous instruction memory with one-cycle read latency.
  always @(posedge clk) imem_data <= instr_of(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic restart_exp(input logic [31:0] start);
    logic [31:0] pc;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back('{pc: pc, instr: instr_of(pc >> 2)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: a pop in a redirect cycle is void, so it is not scored.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      n_popped++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h, expected no output", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    // Reset release then stream; cycle 0 begins here.
    tick(); rst = 1'b0; restart_exp(32'h0);
    mid(); chk("c0_addr", imem_addr, 32'd0); chk("c0_valid", 32'(out_valid), 32'd0);
    tick(); mid(); chk("c1_addr", imem_addr, 32'd1); chk("c1_valid", 32'(out_valid), 32'd0);
    tick(); mid(); chk("c2_valid", 32'(out_valid), 32'd1); chk("c2_pc", out_pc, 32'h0);
    chk("c2_instr", out_instr, 32'h0000_0000);
    tick(); mid(); chk("c3_pc", out_pc, 32'h4); chk("c3_instr", out_instr, 32'h2003_0001);
    tick(); mid(); chk("c4_pc", out_pc, 32'h8); chk("c4_instr", out_instr, 32'h2203_0001);

    // Redirect mid-stream in cycle 5.
    tick(); chk("stream_pops", 32'(n_popped), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; restart_exp(32'h100);
    mid();
    tick(); redirect_valid = 1'b0;
    mid(); chk("r6_addr", imem_addr, 32'h40); chk("r6_valid", 32'(out_valid), 32'd0);
    tick(); mid(); chk("r7_valid", 32'(out_valid), 32'd0);
    tick(); mid(); chk("r8_valid", 32'(out_valid), 32'd1); chk("r8_pc", out_pc, 32'h100);

    // Backpressure: restart at 0 with decode stalled for 10 cycles.
    tick(); out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0; restart_exp(32'h0);
    p0 = n_popped;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) redirect_valid = 1'b0;
      mid();
      chk("bp_addr", imem_addr, (k < 5) ? 32'(k - 1) : 32'd4);
    end
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    chk("bp_head_pc", out_pc, 32'h0);
    for (int k = 10; k <= 14; k++) begin
      tick();
      if (k == 10) begin
        out_ready = 1'b1;
        chk("bp_no_pop", 32'(n_popped - p0), 32'd0);
      end
      mid();
      chk("drain_pc", out_pc, 32'(4 * (k - 10)));
    end

    // Fill the FIFO, then redirect with a pop in the same cycle.
    tick(); chk("drain_pops", 32'(n_popped - p0), 32'd5);
    out_ready = 1'b0;
    repeat (6) tick();
    mid(); chk("full_valid", 32'(out_valid), 32'd1);
    tick(); out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; restart_exp(32'h200);
    mid();
    tick(); redirect_valid = 1'b0;
    mid(); chk("fr1_valid", 32'(out_valid), 32'd0); chk("fr1_addr", imem_addr, 32'h80);
    tick(); mid(); chk("fr2_valid", 32'(out_valid), 32'd0);
    tick(); mid(); chk("fr3_pc", out_pc, 32'h200);

    // PC wrap at the top of the address space.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; restart_exp(32'hFFFF_FFF8);
    tick(); redirect_valid = 1'b0;
    tick();
    tick(); mid(); chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    tick(); mid(); chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    tick(); mid(); chk("wrap_pc2", out_pc, 32'h0000_0000); chk("wrap_valid", 32'(out_valid), 32'd1);

    // Async reset asserted between clock edges.
    tick(); #2; rst = 1'b1; #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    tick(); tick(); mid(); chk("arst_hold", 32'(out_valid), 32'd0);
    tick(); rst = 1'b0; restart_exp(32'h0);
    mid(); chk("e0_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_0", perf_fetch_cnt, 32'd0);
    chk("perf_flush_0", perf_flush_cnt, 32'd0);
`endif
    tick(); mid();
    tick(); mid(); chk("e2_pc", out_pc, 32'h0); chk("e2_valid", 32'(out_valid), 32'd1);
    tick(); tick();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; restart_exp(32'h40);
    mid();
`ifdef FETCH_PERF_EN
    chk("perf_fetch_5", perf_fetch_cnt, 32'd5);
`endif
    tick(); redirect_valid = 1'b0; mid();
`ifdef FETCH_PERF_EN
    chk("perf_flush_1", perf_flush_cnt, 32'd1);
    chk("perf_fetch_hold", perf_fetch_cnt, 32'd5);
`endif
    tick(); mid();
`ifdef FETCH_PERF_EN
    chk("perf_fetch_6", perf_fetch_cnt, 32'd6);
`endif
    tick(); mid(); chk("e8_pc", out_pc, 32'h40);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
